keypad_scanner: RTL and testbench

- Drives the rows of the 4x4 matrix keypad and samples its columns.
- Debounces a single key press and releases one-hot `key_row`/`key_col` plus a one-cycle `en` strobe.
- These outputs feed `fsm_decoder`'s `row`/`col`/`en` inputs.
- Generates exactly one `en` per physical press, however long the key is held.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/sync2.sv | 41 ++++
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and helpers for the keypad scanner
//
// Purpose: holds the scanner FSM state type, the row drive that follows reset,
//          and the one-hot test that decides whether a column sample is a key.
// Ports:   none (package).

package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   localparam logic [3:0] ROW_RESET = 4'b0001;

   // Exactly one column high counts as a key. Zero keys and chorded keys in
   // the same row both count as "no key".
   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous inputs
//
// Purpose: brings an asynchronous bus into the clk domain through two flops.
// Ports:
//    clk    in            sampling clock
//    rst_n  in            asynchronous active-low reset, clears both stages
//    d      in  [WIDTH]   asynchronous input
//    q      out [WIDTH]   synchronized output, two clocks behind d

module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] meta_d;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad row scanner with press/release debounce
//
// Purpose: walks a one-hot drive across the four keypad rows, samples the
//          synchronized columns at the end of each row's dwell, debounces a
//          single key, and reports it once per physical press.
// Ports:
//    clk      in      system clock
//    reset    in      asynchronous active-low reset
//    col      in  [4] raw column pins (active-high, pulled down on the board)
//    row      out [4] one-hot row drive (registered)
//    key_row  out [4] one-hot row of the last accepted key
//    key_col  out [4] one-hot column of the last accepted key
//    en       out     one-cycle strobe, key_row/key_col updated this cycle

module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 2400,
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key_row,
   output logic [3:0] key_col,
   output logic       en
);

   localparam int DC_W = $clog2(SCAN_CYCLES);
   localparam int BC_W = $clog2(DEBOUNCE_CYCLES);

   localparam logic [DC_W-1:0] DC_LAST = DC_W'(SCAN_CYCLES - 1);
   localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

   logic [3:0]      cs;

   scan_state_t     state_q,   state_d;
   logic [1:0]      ri_q,      ri_d;
   logic [3:0]      row_q,     row_d;
   logic [DC_W-1:0] dc_q,      dc_d;
   logic [BC_W-1:0] bc_q,      bc_d;
   logic [3:0]      cap_q,     cap_d;
   logic [3:0]      key_row_q, key_row_d;
   logic [3:0]      key_col_q, key_col_d;
   logic            en_q,      en_d;

   logic            cap_hit;

   sync2 #(
      .WIDTH (4)
   ) u_col_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (col),
      .q     (cs)
   );

   // In HELD/RELEASE only the captured column matters, so extra keys in the
   // same row neither end the hold nor start a new press.
   assign cap_hit = |(cs & cap_q);

   always_comb begin
      state_d   = state_q;
      ri_d      = ri_q;
      dc_d      = dc_q;
      bc_d      = bc_q;
      cap_d     = cap_q;
      key_row_d = key_row_q;
      key_col_d = key_col_q;
      en_d      = 1'b0;

      case (state_q)
         SCAN: begin
            // Sample only on the last dwell cycle so the columns have had
            // SCAN_CYCLES-1 cycles (including the synchronizer) to settle.
            if (dc_q == DC_LAST) begin
               if (onehot4(cs)) begin
                  cap_d   = cs;
                  bc_d    = '0;
                  state_d = DEBOUNCE;
               end else begin
                  ri_d = ri_q + 2'd1;
                  dc_d = '0;
               end
            end else begin
               dc_d = dc_q + DC_ONE;
            end
         end

         DEBOUNCE: begin
            if (cs != cap_q) begin
               state_d = SCAN;
               ri_d    = ri_q + 2'd1;
               dc_d    = '0;
            end else if (bc_q == BC_LAST) begin
               key_row_d = row_q;
               key_col_d = cap_q;
               en_d      = 1'b1;
               state_d   = HELD;
            end else begin
               bc_d = bc_q + BC_ONE;
            end
         end

         HELD: begin
            if (!cap_hit) begin
               bc_d    = '0;
               state_d = RELEASE;
            end
         end

         RELEASE: begin
            if (cap_hit) begin
               // Release bounce: resume holding without a new strobe.
               state_d = HELD;
            end else if (bc_q == BC_LAST) begin
               state_d = SCAN;
               ri_d    = ri_q + 2'd1;
               dc_d    = '0;
            end else begin
               bc_d = bc_q + BC_ONE;
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase

      // The row drive is registered from the next row index so that row never
      // depends combinationally on anything.
      row_d = ROW_RESET << ri_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= SCAN;
         ri_q      <= 2'd0;
         row_q     <= ROW_RESET;
         dc_q      <= '0;
         bc_q      <= '0;
         cap_q     <= 4'b0000;
         key_row_q <= 4'b0000;
         key_col_q <= 4'b0000;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ri_q      <= ri_d;
         row_q     <= row_d;
         dc_q      <= dc_d;
         bc_q      <= bc_d;
         cap_q     <= cap_d;
         key_row_q <= key_row_d;
         key_col_q <= key_col_d;
         en_q      <= en_d;
      end
   end

   assign row     = row_q;
   assign key_row = key_row_q;
   assign key_col = key_col_q;
   assign en      = en_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a keypad matrix model

module tb_keypad_scanner;

   localparam int SC      = 4;
   localparam int DB      = 8;
   localparam int MAX_LAT = 2 + 4 * SC + DB + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key_row;
   logic [3:0] key_col;
   logic       en;

   // keys[r] = column mask of keys currently held down in row r
   logic [3:0] keys [4];

   int         n_checks = 0;
   int         n_fail   = 0;
   int         en_count = 0;
   int         n_expected = 0;
   logic       en_prev = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_item;

   always #5 clk = ~clk;

   // Passive matrix: a driven row connects each pressed key to its column.
   always_comb begin
      col = 4'b0000;
      for (int r = 0; r < 4; r++) begin
         if (row[r]) col = col | keys[r];
      end
   end

   keypad_scanner #(
      .SCAN_CYCLES     (SC),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .col     (col),
      .row     (row),
      .key_row (key_row),
      .key_col (key_col),
      .en      (en)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe must match the oldest outstanding press.
   always @(negedge clk) begin
      if (reset && en) begin
         en_count++;
         check_eq("en_single_cycle", 32'(en_prev), 32'd0);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_en", 32'(en), 32'd0);
         end else begin
            exp_item = exp_q.pop_front();
            check_eq("key_row", 32'(key_row), 32'(exp_item[7:4]));
            check_eq("key_col", 32'(key_col), 32'(exp_item[3:0]));
         end
      end
      en_prev = en;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_expect(input int r, input logic [3:0] c, input string tag);
      logic [3:0] rm;
      int         lat;
      rm = 4'b0001 << r;
      exp_q.push_back({rm, c});
      n_expected++;
      keys[r] = c;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!en && lat < 60);
      check_eq({tag, "_en_seen"}, 32'(en), 32'd1);
      check_eq({tag, "_latency_le_max"}, 32'(lat <= MAX_LAT), 32'd1);
   endtask

   // Must be called on the negedge where reset is released, with no keys down.
   task automatic idle_scan_check(input string tag);
      logic [3:0] exp_row;
      for (int k = 0; k < 32; k++) begin
         exp_row = 4'b0001 << ((k / 4) % 4);
         check_eq(tag, 32'(row), 32'(exp_row));
         @(negedge clk);
      end
   endtask

   task automatic reset_state_check(input string tag);
      check_eq({tag, "_row"},     32'(row),     32'h1);
      check_eq({tag, "_key_row"}, 32'(key_row), 32'h0);
      check_eq({tag, "_key_col"}, 32'(key_col), 32'h0);
      check_eq({tag, "_en"},      32'(en),      32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         base;
      int         w;
      logic [3:0] prev_row;

      for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
      reset = 1'b0;
      cycles(3);
      reset_state_check("por");
      reset = 1'b1;
      idle_scan_check("idle_row_por");

      // Single press (row 0010, col 0100) held for 200 cycles.
      press_expect(1, 4'b0100, "single");
      for (int i = 0; i < 10; i++) begin
         cycles(20);
         check_eq("single_row_held", 32'(row), 32'h2);
      end
      keys[1] = 4'b0000;
      cycles(40);

      // Press bounce, then a stable press, then release bounce.
      base = en_count;
      for (int i = 0; i < 10; i++) begin
         keys[1] = (i % 2 == 0) ? 4'b0100 : 4'b0000;
         cycles(3);
      end
      check_eq("bounce_press_no_en", 32'(en_count), 32'(base));
      press_expect(1, 4'b0100, "bounce");
      cycles(20);
      base = en_count;
      for (int i = 0; i < 10; i++) begin
         keys[1] = (i % 2 == 0) ? 4'b0000 : 4'b0100;
         cycles(3);
      end
      keys[1] = 4'b0000;
      cycles(40);
      check_eq("bounce_release_no_en", 32'(en_count), 32'(base));

      // Reset in the middle of DEBOUNCE for a key on row 0100.
      w = 0;
      while (row != 4'b0001 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check_eq("mid_wait_row0", 32'(row), 32'h1);
      keys[2] = 4'b0001;
      prev_row = row;
      w = 0;
      do begin
         prev_row = row;
         @(negedge clk);
         w++;
      end while (!(row == 4'b0100 && prev_row != 4'b0100) && w < 40);
      check_eq("mid_wait_row2", 32'(row), 32'h4);
      base = en_count;
      cycles(7);
      reset = 1'b0;
      #1;
      reset_state_check("mid_debounce_reset");
      keys[2] = 4'b0000;
      cycles(2);
      reset_state_check("mid_debounce_reset_hold");
      check_eq("mid_debounce_no_en", 32'(en_count), 32'(base));
      reset = 1'b1;
      idle_scan_check("idle_row_restart");

      // Two keys in one row are never accepted.
      base = en_count;
      keys[2] = 4'b0110;
      cycles(60);
      keys[2] = 4'b0000;
      cycles(10);
      check_eq("multikey_no_en", 32'(en_count), 32'(base));

      // Hold col 0001, add col 1000 in the same row: no extra strobe.
      press_expect(0, 4'b0001, "hold_base");
      cycles(10);
      base = en_count;
      keys[0] = 4'b1001;
      cycles(40);
      check_eq("hold_extra_no_en", 32'(en_count), 32'(base));
      check_eq("hold_extra_row", 32'(row), 32'h1);
      keys[0] = 4'b0000;
      cycles(40);

      press_expect(3, 4'b0010, "row3");
      cycles(20);
      keys[3] = 4'b0000;
      cycles(40);

      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check_eq("en_total", 32'(en_count), 32'(n_expected));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
